emif_hs_regs: RTL and testbench



---
 rtl/emif_hs_regs_pkg.sv | 16 +
 rtl/emif_hs_regs_if.sv | 22 ++
 rtl/emif_hs_regs.sv | 101 ++++++++++
 tb/tb_emif_hs_regs.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/emif_hs_regs_pkg.sv
// Shared types for the EMIF conditional valid/ready register slice.
// The state encoding is visible here so checkers can name states symbolically.
package emif_hs_regs_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Upstream may push whenever the slice will not be holding two beats.
  function automatic logic can_accept(input state_e s);
    return (s != FULL);
  endfunction

endpackage

// File: rtl/emif_hs_regs_if.sv
// Valid/ready payload bundle used to wire C2P/P2C Avalon streams around the slice.
// A beat transfers on a clock edge where valid && ready; the source holds valid and
// data stable until that edge, and ready may be sampled only together with valid.
interface emif_hs_regs_if #(
  parameter int WIDTH = 1
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport source (
    output valid,
    output data,
    input  ready
  );

  modport sink (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/emif_hs_regs.sv
// Conditional valid/ready register slice: wire-through when REGISTER == 0, otherwise a
// two-entry skid buffer that registers both the forward payload and the backward ready.
module emif_hs_regs
  import emif_hs_regs_pkg::*;
#(
  parameter int REGISTER = 0,
  parameter int WIDTH    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  generate
    if (REGISTER == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, reset_n};

      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign in_ready  = out_ready;
    end else begin : g_reg
      (* dont_merge, altera_attribute = "-name AUTO_SHIFT_REGISTER_RECOGNITION OFF" *)
      state_e           state_q;
      (* dont_merge, altera_attribute = "-name AUTO_SHIFT_REGISTER_RECOGNITION OFF" *)
      logic [WIDTH-1:0] main_q;
      (* dont_merge, altera_attribute = "-name AUTO_SHIFT_REGISTER_RECOGNITION OFF" *)
      logic [WIDTH-1:0] skid_q;
      (* dont_merge, altera_attribute = "-name AUTO_SHIFT_REGISTER_RECOGNITION OFF" *)
      logic             ready_q;

      state_e           state_d;
      logic [WIDTH-1:0] main_d;
      logic [WIDTH-1:0] skid_d;
      logic             ready_d;
      logic             in_fire;

      assign in_fire = in_valid && ready_q;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
          EMPTY: begin
            if (in_fire) begin
              state_d = ONE;
              main_d  = in_data;
            end
          end
          ONE: begin
            if (in_fire && out_ready) begin
              main_d = in_data;
            end else if (in_fire) begin
              // Output stalled: the beat that slipped in during the ready lag goes to skid.
              state_d = FULL;
              skid_d  = in_data;
            end else if (out_ready) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            if (out_ready) begin
              state_d = ONE;
              main_d  = skid_q;
            end
          end
          default: begin
            state_d = EMPTY;
          end
        endcase
        // Ready is registered from the next state, so out_ready never reaches in_ready combinationally.
        ready_d = can_accept(state_d);
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state_q <= EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
          ready_q <= 1'b0;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
          ready_q <= ready_d;
        end
      end

      assign out_valid = (state_q != EMPTY);
      assign out_data  = main_q;
      assign in_ready  = ready_q;
    end
  endgenerate

endmodule

// File: tb/tb_emif_hs_regs.sv
// Bench for emif_hs_regs: registered slice against a 2-deep FIFO reference model,
// plus a pass-through instance checked for same-cycle equality.
module tb_emif_hs_regs;

  localparam int W = 8;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         ov;
    logic [W-1:0] od;
    logic         ir;
  } vec_t;

  logic clk;
  logic reset_n;

  emif_hs_regs_if #(.WIDTH(W)) up_r ();
  emif_hs_regs_if #(.WIDTH(W)) dn_r ();
  emif_hs_regs_if #(.WIDTH(W)) up_p ();
  emif_hs_regs_if #(.WIDTH(W)) dn_p ();

  emif_hs_regs #(.REGISTER(1), .WIDTH(W)) dut_r (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (up_r.valid),
    .in_ready  (up_r.ready),
    .in_data   (up_r.data),
    .out_valid (dn_r.valid),
    .out_ready (dn_r.ready),
    .out_data  (dn_r.data)
  );

  emif_hs_regs #(.REGISTER(0), .WIDTH(W)) dut_p (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (up_p.valid),
    .in_ready  (up_p.ready),
    .in_data   (up_p.data),
    .out_valid (dn_p.valid),
    .out_ready (dn_p.ready),
    .out_data  (dn_p.data)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Scoreboard: beats accepted but not yet delivered, oldest first.
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pass-through instance: random inputs, outputs must follow in the same cycle.
  task automatic pt_check();
    up_p.valid = 1'($urandom_range(0, 1));
    up_p.data  = W'($urandom_range(0, 255));
    dn_p.ready = 1'($urandom_range(0, 1));
    #1;
    check("pt_valid", dn_p.valid, up_p.valid);
    check("pt_data",  dn_p.data,  up_p.data);
    check("pt_ready", up_p.ready, dn_p.ready);
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy);
    up_r.valid = iv;
    up_r.data  = d;
    dn_r.ready = ordy;
  endtask

  // One clock: starts between edges, ends at the following negedge with the model updated
  // and all registered-slice outputs checked against it.
  task automatic tick();
    logic         fi, fo, stall;
    logic [W-1:0] in_d, held_d;
    pt_check();
    fi     = up_r.valid && up_r.ready;
    fo     = dn_r.valid && dn_r.ready;
    stall  = dn_r.valid && !dn_r.ready;
    in_d   = up_r.data;
    held_d = dn_r.data;
    @(posedge clk);
    @(negedge clk);
    if (fo) begin
      check("out_fire_has_beat", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (fi) exp_q.push_back(in_d);
    check("model_out_valid", dn_r.valid, 32'(exp_q.size() != 0));
    check("model_in_ready",  up_r.ready, 32'(exp_q.size() < 2));
    if (exp_q.size() != 0) check("model_out_data", dn_r.data, exp_q[0]);
    if (stall) begin
      check("stall_data_stable",  dn_r.data,  held_d);
      check("stall_valid_stable", dn_r.valid, 32'd1);
    end
  endtask

  vec_t stall_tab[5];

  initial begin
    stall_tab[0] = '{iv: 1'b1, d: 8'hA1, ordy: 1'b0, ov: 1'b1, od: 8'hA1, ir: 1'b1};
    stall_tab[1] = '{iv: 1'b1, d: 8'hA2, ordy: 1'b0, ov: 1'b1, od: 8'hA1, ir: 1'b0};
    stall_tab[2] = '{iv: 1'b1, d: 8'hA3, ordy: 1'b0, ov: 1'b1, od: 8'hA1, ir: 1'b0};
    stall_tab[3] = '{iv: 1'b0, d: 8'h00, ordy: 1'b1, ov: 1'b1, od: 8'hA2, ir: 1'b1};
    stall_tab[4] = '{iv: 1'b0, d: 8'h00, ordy: 1'b1, ov: 1'b0, od: 8'hA2, ir: 1'b1};

    reset_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    up_p.valid = 1'b0;
    up_p.data  = '0;
    dn_p.ready = 1'b0;
    #1 reset_n = 1'b0;

    // Reset values held across edges
    pt_check();
    @(negedge clk);
    pt_check();
    @(negedge clk);
    check("rst_out_valid", dn_r.valid, 32'd0);
    check("rst_in_ready",  up_r.ready, 32'd0);
    check("rst_out_data",  dn_r.data,  32'd0);
    #1 reset_n = 1'b1;
    tick();
    check("in_ready_after_reset", up_r.ready, 32'd1);

    // Back-to-back stream with out_ready high
    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, W'(k), 1'b1);
      tick();
      check("stream_data",  dn_r.data,  32'(k));
      check("stream_valid", dn_r.valid, 32'd1);
      check("stream_ready", up_r.ready, 32'd1);
    end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    check("stream_drained", dn_r.valid, 32'd0);

    // Stall absorption and release
    for (int i = 0; i < 5; i++) begin
      drive(stall_tab[i].iv, stall_tab[i].d, stall_tab[i].ordy);
      tick();
      check($sformatf("stall_tab%0d_valid", i), dn_r.valid, stall_tab[i].ov);
      check($sformatf("stall_tab%0d_data", i),  dn_r.data,  stall_tab[i].od);
      check($sformatf("stall_tab%0d_ready", i), up_r.ready, stall_tab[i].ir);
    end

    // Reset pulse while FULL
    drive(1'b1, 8'h55, 1'b0);
    tick();
    drive(1'b1, 8'h66, 1'b0);
    tick();
    check("pre_reset_full_ready", up_r.ready, 32'd0);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", dn_r.valid, 32'd0);
    check("midrst_in_ready",  up_r.ready, 32'd0);
    check("midrst_out_data",  dn_r.data,  32'd0);
    exp_q.delete();
    #1 reset_n = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_no_stale", 32'(dn_r.data != 8'h55 && dn_r.data != 8'h66), 32'd1);
      check("post_rst_empty", dn_r.valid, 32'd0);
    end

    // Random backpressure
    for (int n = 0; n < 10000; n++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      tick();
    end
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    check("random_final_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
